wb_arbiter_intercon: RTL

WB_ARBITER_INTERCON -- requirements
Module: wb_arbiter_intercon

---
 rtl/wb_arbiter_intercon.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter_intercon.sv
// Round-robin Wishbone arbiter + address-decoded interconnect; grant registered, data/ack paths combinational.
// Request seen in IDLE reaches the slave next cycle; bus held until ACK, ERR (timeout/unmapped) or abort.
module wb_arbiter_intercon #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 16,
  parameter int SEL_BITS  = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS-1:0]   master_STB,
  input  logic [N_MASTERS-1:0]   master_WE,
  input  logic [N_MASTERS*32-1:0] master_ADDR,
  input  logic [N_MASTERS*32-1:0] master_DAT_I,
  output logic [N_MASTERS*32-1:0] master_DAT_O,
  output logic [N_MASTERS-1:0]   master_ACK,
  output logic [N_MASTERS-1:0]   master_ERR,
  output logic [N_SLAVES-1:0]    slave_STB,
  input  logic [N_SLAVES-1:0]    slave_ACK,
  output logic                   slave_WE,
  input  logic [N_SLAVES*32-1:0] slave_DAT_I,
  output logic [31:0]            slave_DAT_O,
  output logic [31:0]            slave_ADDR
);
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [15:0]   timer_q, timer_d;

  logic                busy, active, hit, mapped;
  logic                ack, tout_err, unmap_err, found;
  logic                g_stb, g_we, sel_ack;
  logic [31:0]         g_addr, g_dat, sel_dat;
  logic [SEL_BITS-1:0] sel;

  always_comb begin
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_dat  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (int'(grant_q) == i) begin
        g_stb  = master_STB[i];
        g_we   = master_WE[i];
        g_addr = master_ADDR[32*i +: 32];
        g_dat  = master_DAT_I[32*i +: 32];
      end
    end
    sel     = g_addr[31 -: SEL_BITS];
    mapped  = int'(sel) < N_SLAVES;
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (int'(sel) == j) begin
        sel_ack = slave_ACK[j];
        sel_dat = slave_DAT_I[32*j +: 32];
      end
    end
  end

  // Gating on rst makes a mid-transfer reset kill STB/ACK without waiting for the flops.
  assign busy      = (state_q == BUSY) && !rst;
  assign active    = busy && g_stb;
  assign hit       = active && mapped;
  assign ack       = hit && sel_ack;
  assign tout_err  = hit && !sel_ack && (timer_q == 16'(TIMEOUT - 1));
  assign unmap_err = active && !mapped;

  always_comb begin
    slave_ADDR   = '0;
    slave_DAT_O  = '0;
    slave_WE     = 1'b0;
    slave_STB    = '0;
    master_ACK   = '0;
    master_ERR   = '0;
    master_DAT_O = '0;
    if (busy) begin
      slave_ADDR  = g_addr;
      slave_DAT_O = g_dat;
      slave_WE    = g_we;
    end
    for (int j = 0; j < N_SLAVES; j++) begin
      slave_STB[j] = hit && (int'(sel) == j);
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if (int'(grant_q) == i) begin
        master_ACK[i] = ack;
        master_ERR[i] = tout_err || unmap_err;
        if (hit) master_DAT_O[32*i +: 32] = sel_dat;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    found        = 1'b0;
    case (state_q)
      IDLE: begin
        // Search starts one past the last winner so every requester gets its turn.
        for (int k = 1; k <= N_MASTERS; k++) begin
          for (int i = 0; i < N_MASTERS; i++) begin
            if (!found && i == (int'(last_grant_q) + k) % N_MASTERS && master_STB[i]) begin
              grant_d = GW'(i);
              found   = 1'b1;
            end
          end
        end
        if (found) begin
          state_d = BUSY;
          timer_d = '0;
        end
      end
      BUSY: begin
        if (!g_stb || ack || tout_err || unmap_err) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          timer_d      = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_MASTERS - 1);
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
    end
  end
endmodule
